// File: rtl/div_hilo_unit.sv
// EX-stage sequencer for DIV/DIVU around an external combinational divider,
// plus the architectural HI/LO registers (MTHI/MTLO writes, MFHI/MFLO reads).
module div_hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             div_ena,
    output logic             div_sign,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div_ena;
    logic             r_div_sign;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_by_zero;

    logic w_accept;
    logic w_counting;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_counting = (r_state == S_BUSY) && (r_cnt != '0);

    // The commit cycle is not stalled so the DIV can leave EX as hi/lo update.
    assign stall = w_accept || w_counting;
    assign busy  = (r_state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_div_ena     <= 1'b0;
            r_div_sign    <= 1'b0;
            r_div_a       <= '0;
            r_div_b       <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi_we) r_hi <= mt_data;
                    if (mtlo_we) r_lo <= mt_data;
                    if (w_accept) begin
                        r_div_a    <= op_a;
                        r_div_b    <= op_b;
                        r_div_sign <= is_unsigned;
                        r_cnt      <= CNT_LOAD;
                        r_div_ena  <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_div_ena <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Divide-by-zero results are committed unchanged; the flag is informational.
                        r_lo          <= div_q;
                        r_hi          <= div_r;
                        r_div_ena     <= 1'b0;
                        r_state       <= S_IDLE;
                        r_done        <= 1'b1;
                        r_div_by_zero <= (r_div_b == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_ena     = r_div_ena;
    assign div_sign    = r_div_sign;
    assign div_a       = r_div_a;
    assign div_b       = r_div_b;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed bench for div_hilo_unit with a behavioural combinational divider
// attached to the div_a/div_b/div_sign interface.
module tb_div_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        div_ena, div_sign, stall, busy, done, div_by_zero;
    logic [31:0] div_a, div_b, div_q, div_r, hi, lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_hilo_unit #(.WIDTH(32), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_unsigned(is_unsigned),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .div_ena(div_ena), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .hi(hi), .lo(lo),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    // Divider model: x/0 gives all-ones quotient and the dividend as remainder.
    always_comb begin
        div_q = '1;
        div_r = div_a;
        if (div_b != '0) begin
            if (div_sign) begin
                div_q = div_a / div_b;
                div_r = div_a % div_b;
            end else begin
                div_q = $signed(div_a) / $signed(div_b);
                div_r = $signed(div_a) % $signed(div_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz);
        int n;
        start = 1'b1; op_a = a; op_b = b; is_unsigned = uns;
        #1;
        chk({tag, ".stall_issue"}, 32'(stall), 32'd1);
        n = 0;
        while (stall && n < 20) begin
            tick();
            n++;
            chk({tag, ".sign"}, 32'(div_sign), 32'(uns));
            chk({tag, ".div_b"}, div_b, b);
        end
        chk({tag, ".stall_cycles"}, 32'(n), 32'd4);
        chk({tag, ".busy_commit"}, 32'(busy), 32'd1);
        chk({tag, ".ena_commit"}, 32'(div_ena), 32'd1);
        start = 1'b0;
        tick();
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, ".lo"}, lo, eq);
        chk({tag, ".hi"}, hi, er);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        chk({tag, ".ena_after"}, 32'(div_ena), 32'd0);
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        $display("%s: a=%h b=%h uns=%0d -> lo=%h hi=%h dbz=%0d", tag, a, b, uns, lo, hi, edz);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        $display("reset: hi=%h lo=%h", hi, lo);

        run_div("t1_div", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("t2_divu", 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
        run_div("t3_dbz", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);

        // Flush during the second BUSY cycle aborts without commit.
        start = 1'b1; op_a = 32'd100; op_b = 32'd7; is_unsigned = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("t4.stall_flush", 32'(stall), 32'd1);
        tick();
        flush = 1'b0; start = 1'b0;
        chk("t4.busy", 32'(busy), 32'd0);
        chk("t4.lo", lo, 32'hFFFF_FFFF);
        chk("t4.hi", hi, 32'h0000_0005);
        chk("t4.done", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4.no_done", 32'(done), 32'd0);
        end
        $display("t4_flush: hi=%h lo=%h", hi, lo);

        // MTHI in IDLE lands; MTLO during BUSY is dropped.
        mthi_we = 1'b1; mt_data = 32'h1234_5678;
        tick();
        mthi_we = 1'b0;
        chk("t5.mthi", hi, 32'h1234_5678);
        start = 1'b1; op_a = 32'd20; op_b = 32'd3; is_unsigned = 1'b1;
        tick();
        mtlo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
        tick();
        mtlo_we = 1'b0;
        chk("t5.mtlo_busy", lo, 32'hFFFF_FFFF);
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("t5.commit_lo", lo, 32'd6);
        chk("t5.commit_hi", hi, 32'd2);
        $display("t5_mt: hi=%h lo=%h", hi, lo);

        // MTHI+MTLO together, and an MTLO coinciding with the DIV issue.
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hA5A5_0001;
        tick();
        mthi_we = 1'b0;
        chk("t5b.hi", hi, 32'hA5A5_0001);
        chk("t5b.lo", lo, 32'hA5A5_0001);
        mt_data = 32'h0000_BEEF; start = 1'b1; op_a = 32'd50; op_b = 32'd8; is_unsigned = 1'b1;
        tick();
        mtlo_we = 1'b0;
        chk("t5b.lo_issue", lo, 32'h0000_BEEF);
        tick(); tick(); tick();
        start = 1'b0;
        tick();
        chk("t5b.lo_commit", lo, 32'd6);
        chk("t5b.hi_commit", hi, 32'd2);
        $display("t5b_mt_both: hi=%h lo=%h", hi, lo);

        // Reset mid-BUSY clears everything, then a fresh DIV works.
        start = 1'b1; op_a = 32'd100; op_b = 32'd7; is_unsigned = 1'b1;
        tick();
        tick();
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6.hi", hi, 32'd0);
        chk("t6.lo", lo, 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.ena", 32'(div_ena), 32'd0);
        chk("t6.sign", 32'(div_sign), 32'd0);
        chk("t6.div_a", div_a, 32'd0);
        chk("t6.div_b", div_b, 32'd0);
        chk("t6.done", 32'(done), 32'd0);
        chk("t6.dbz", 32'(div_by_zero), 32'd0);
        chk("t6.stall", 32'(stall), 32'd0);
        tick();
        $display("t6_rst: hi=%h lo=%h", hi, lo);
        run_div("t6_div", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
